mux8_scan_sequencer: RTL
========================

Name: mux8_scan_sequencer

Overview:
- Sequencer that drives the 3-bit select of an 8:1 mux tree built from mux2 cells (S0 on the leaf level, S2 on the root).
- Walks the tree through channels 0..7 and waits a programmable settle time after each select change.
- Samples the single tree output into an 8-bit frame and hands the frame downstream with a valid/ready handshake.
- Sits directly around the mux tree: it is the select source upstream of the tree and the consumer of the tree output downstream.

Parameters:
- SETTLE_CYCLES, 2: clock cycles each select value is held before mux_out is sampled. Legal range 1..15.
- CNT_W, 4: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  clock enable. When low, all state holds.
- start  input  1  single-cycle request to begin a scan.
- mux_out  input  1  output of the mux tree.
- sel  output  3  mux tree select. sel[0] drives the leaf-level S, sel[2] drives the root S.
- frame  output  8  captured frame. Bit k = mux_out sampled while sel==k.
- frame_valid  output  1  frame is complete and stable.
- frame_ready  input  1  downstream accepts the frame.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sel=0, frame=0x00, frame_valid=0, busy=0, settle counter=0.
- ena low: no state, counter, sel or frame change. Inputs are ignored. Outputs hold their values.
- States: IDLE, SETTLE, HOLD. All transitions below occur on rising clk edges with ena=1.
- IDLE:
  - start=1 -> SETTLE, sel=0, cnt=SETTLE_CYCLES.
  - start=0 -> stay in IDLE.
  - frame keeps the last captured value.
- SETTLE, cnt>1: cnt decrements by 1.
- SETTLE, cnt==1:
  - frame[sel] <= mux_out.
  - If sel<7: sel increments, cnt reloads to SETTLE_CYCLES.
  - If sel==7: go to HOLD, frame_valid=1, sel stays at 7.
- SETTLE timing: each channel occupies exactly SETTLE_CYCLES cycles. frame_valid rises on edge 8*SETTLE_CYCLES after the start edge (edge 16 for the default).
- frame bits of channels not yet sampled in the current scan keep their previous values. frame bits are not cleared at scan start.
- HOLD:
  - frame and sel stay stable while frame_valid=1.
  - frame_valid=1 and frame_ready=1 on an edge -> handshake done: frame_valid=0, state=IDLE, sel=0.
  - frame_ready=0 -> wait indefinitely.
- frame_ready is ignored when frame_valid=0.
- start while busy=1 is ignored, including start in HOLD. Start requests are not queued.
- The handshake completes in the cycle it is offered. A start in the edge after the handshake is accepted normally.
- No combinational path from any input to any output. All outputs are registered.
- rst_n asserted mid-scan or in HOLD: immediate return to reset values. The partial frame is discarded.

Optional Feature:
- Macro: MUX8SCAN_CONT_EN.
- Defined: continuous scan mode.
  - A handshake in HOLD goes directly to SETTLE with sel=0 and cnt=SETTLE_CYCLES instead of IDLE.
  - The first scan still requires start.
  - start=1 coincident with the handshake has no additional effect.
  - busy stays 1 from the first start until reset.
- Undefined: behaviour as specified above. One scan per start.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high with start=0 for 20 cycles -> sel=0, frame=0x00, frame_valid=0, busy=0 throughout.
- Basic scan: SETTLE_CYCLES=2, mux_out modeled as bit sel of 0xA5, start pulse at edge 0 -> sel steps 0..7 every 2 cycles, frame_valid=1 at edge 16, frame=0xA5. frame_ready=1 at edge 18 -> IDLE at edge 18, sel=0, busy=0.
- Backpressure and ignored start: hold frame_ready=0 for 50 cycles in HOLD, pulse start mid-wait -> frame stays 0xA5, frame_valid stays 1, sel stays 7, no new scan. Release ready -> one handshake only.
- Settle and ena: SETTLE_CYCLES=3, pattern 0x3C, ena low for 5 cycles during channel 4 -> sel=4 held 8 cycles total, frame=0x3C, frame_valid at edge 24+5.
- Reset mid-scan: assert rst_n low asynchronously (between edges) while sel=5 -> outputs go to reset values immediately. Next start, pattern 0xFF -> frame=0xFF.
- Continuous mode (MUX8SCAN_CONT_EN defined): start once, frame_ready tied 1, pattern toggling 0x0F/0xF0 per scan -> frame_valid pulses every 16 cycles + 1 handshake cycle, frames alternate 0x0F, 0xF0, busy stays 1.

Source files
------------

// File: rtl/mux8_scan_sequencer_if.sv
// Signal bundle between the scan sequencer, the 8:1 mux tree and the frame consumer.
// master = sequencer side, slave = environment side (mux tree, start source, frame sink).
interface mux8_scan_sequencer_if;
  logic       start;
  logic       busy;
  logic [2:0] sel;
  logic       mux_out;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_ready;

  modport master (
    input  start, mux_out, frame_ready,
    output busy, sel, frame, frame_valid
  );

  modport slave (
    output start, mux_out, frame_ready,
    input  busy, sel, frame, frame_valid
  );
endinterface

// File: rtl/mux8_scan_sequencer.sv
// Walks an 8:1 mux2 tree through channels 0..7, samples its output after a settle time
// and offers the 8-bit frame downstream over valid/ready. Define MUX8SCAN_CONT_EN for continuous scanning.
module mux8_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  mux8_scan_sequencer_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       sel, sel_n;
  logic [7:0]       frame, frame_n;
  logic             frame_valid, frame_valid_n;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    state_n       = state;
    cnt_n         = cnt;
    sel_n         = sel;
    frame_n       = frame;
    frame_valid_n = frame_valid;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SETTLE;
          sel_n   = 3'd0;
          cnt_n   = RELOAD;
        end
      end

      SETTLE: begin
        if (cnt > ONE) begin
          cnt_n = cnt - ONE;
        end else begin
          // Last cycle of this channel: the tree output has settled for the full window.
          frame_n[sel] = bus.mux_out;
          if (sel != 3'd7) begin
            sel_n = sel + 3'd1;
            cnt_n = RELOAD;
          end else begin
            state_n       = HOLD;
            frame_valid_n = 1'b1;
          end
        end
      end

      HOLD: begin
        if (bus.frame_ready) begin
          frame_valid_n = 1'b0;
          sel_n         = 3'd0;
`ifdef MUX8SCAN_CONT_EN
          state_n = SETTLE;
          cnt_n   = RELOAD;
`else
          state_n = IDLE;
`endif
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= 3'd0;
      frame       <= 8'h00;
      frame_valid <= 1'b0;
    end else if (ena) begin
      state       <= state_n;
      cnt         <= cnt_n;
      sel         <= sel_n;
      frame       <= frame_n;
      frame_valid <= frame_valid_n;
    end
  end

  assign bus.sel         = sel;
  assign bus.frame       = frame;
  assign bus.frame_valid = frame_valid;
  assign bus.busy        = (state != IDLE);

endmodule
